// File: rtl/seg7_pkg.sv
// Shared types, constants and digit/glyph helpers for the seven-segment scan driver.
package seg7_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned AN_W   = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [AN_W-1:0]  AN_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        MODE_BIN = 2'd0,
        MODE_OCT = 2'd1,
        MODE_HEX = 2'd2,
        MODE_BCD = 2'd3
    } disp_mode_e;

    // One complete display request as accepted from the source.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        disp_mode_e        mode;
        logic              blank_lz;
    } disp_val_t;

    localparam disp_val_t DISP_RST = '{data: '0, mode: MODE_HEX, blank_lz: 1'b0};

    // Active-low {g,f,e,d,c,b,a} glyph for a hex digit.
    function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Raw digit at position idx of a value, according to its encoding.
    function automatic logic [3:0] digit_of(input logic [DATA_W-1:0] value,
                                            input disp_mode_e        mode,
                                            input logic [2:0]        idx);
        logic [3:0] dig;
        case (mode)
            MODE_BIN: dig = {3'b000, value[idx]};
            MODE_OCT: dig = {1'b0, 3'(value >> ({2'b00, idx} * 5'd3))};
            default:  dig = 4'(value >> {idx, 2'b00});
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Maps one raw digit to its active-low segment pattern; out-of-range BCD shows a dash.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  disp_mode_e       mode_i,
    input  logic [3:0]       raw_i,
    output logic [SEG_W-1:0] seg_c_o,
    output logic             invalid_c_o
);

    always_comb begin
        invalid_c_o = (mode_i == MODE_BCD) && (raw_i > 4'd9);
        seg_c_o     = invalid_c_o ? SEG_DASH : hex_glyph(raw_i);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with frame-aligned value swaps,
// leading-zero blanking and per-slot ghost-suppression blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 2,
    parameter int unsigned NUM_DIGITS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic              in_blank_lz,
    output logic [AN_W-1:0]   an,
    output logic [SEG_W-1:0]  seg,
    output logic              dp,
    output logic              bcd_err
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    disp_val_t        pend_q, pend_d;
    disp_val_t        shadow_q, shadow_d;
    logic             ready_q, ready_d;
    logic [AN_W-1:0]  an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             bcd_err_q, bcd_err_d;

    logic [3:0]            dig_raw [NUM_DIGITS];
    logic [SEG_W-1:0]      dig_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dig_nz;
    logic [NUM_DIGITS-1:0] dig_inv;

    logic             tick_c;
    logic             boundary_c;
    logic             accept_c;
    logic             blank_c;
    logic [IDX_W-1:0] msd_c;

    // Every digit of the shown value is decoded so BCD errors and blanking see the whole value.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign dig_raw[g] = digit_of(shadow_q.data, shadow_q.mode, IDX_W'(g));
        assign dig_nz[g]  = |dig_raw[g];

        seg7_digit_decode u_decode (
            .mode_i      (shadow_q.mode),
            .raw_i       (dig_raw[g]),
            .seg_c_o     (dig_seg[g]),
            .invalid_c_o (dig_inv[g])
        );
    end

    // Most-significant nonzero displayed digit; stays 0 for an all-zero value.
    always_comb begin
        msd_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_nz[i]) begin
                msd_c = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        shadow_d  = shadow_q;
        an_d      = AN_OFF;
        seg_d     = SEG_BLANK;

        tick_c     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        boundary_c = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
        accept_c   = in_valid && ready_q;
        blank_c    = shadow_q.blank_lz && (idx_q > msd_c);

        if (tick_c) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // in_ready is low whenever pending is set, so accept and swap never coincide.
        if (accept_c) begin
            pending_d = 1'b1;
            pend_d    = '{data: in_data, mode: disp_mode_e'(in_mode), blank_lz: in_blank_lz};
        end else if (boundary_c && pending_q) begin
            pending_d = 1'b0;
            shadow_d  = pend_q;
        end

        ready_d   = !pending_d;
        bcd_err_d = |dig_inv;

        // Segments follow the new digit immediately; the anode waits out the blank window.
        if (!blank_c) begin
            seg_d = dig_seg[idx_q];
            if (cnt_q >= CNT_W'(BLANK_CYC)) begin
                an_d = ~(AN_W'(1) << idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            pend_q    <= DISP_RST;
            shadow_q  <= DISP_RST;
            ready_q   <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
            bcd_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            shadow_q  <= shadow_d;
            ready_q   <= ready_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            bcd_err_q <= bcd_err_d;
        end
    end

    assign in_ready = ready_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign bcd_err  = bcd_err_q;
    assign dp       = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random traffic,
// compared every cycle against a frame/slot arithmetic model of the display.
module tb_seg7_scan_driver;

    localparam int SLOT  = 4;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  in_mode = 2'd0;
    logic        in_blank_lz = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        bcd_err;

    int n_checks = 0;
    int n_pass   = 0;

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYC   (1),
        .NUM_DIGITS  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .in_blank_lz (in_blank_lz),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .bcd_err     (bcd_err)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: edges since reset, pending/shown values, expected outputs.
    int          m_t = 0;
    bit          m_pend = 0;
    logic [31:0] m_pd = 0;
    logic [1:0]  m_pm = 2;
    logic        m_pb = 0;
    logic [31:0] m_sv = 0;
    logic [1:0]  m_sm = 2;
    logic        m_sb = 0;
    bit          m_ready = 0;
    bit          m_acc = 0;
    int          m_acc_t = 0;
    logic [7:0]  e_an = 8'hFF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_bcd = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, got, exp, m_t);
    endtask

    function automatic int dig_at(input logic [31:0] v, input logic [1:0] mode, input int pos);
        longint unsigned q = 64'(v);
        longint unsigned radix = (mode == 2'd0) ? 2 : (mode == 2'd1) ? 8 : 16;
        for (int k = 0; k < pos; k++) q = q / radix;
        return int'(q % radix);
    endfunction

    function automatic bit is_blanked(input logic [31:0] v, input logic [1:0] mode,
                                      input logic blz, input int pos);
        int msd = 0;
        if (!blz) return 1'b0;
        for (int i = 0; i < 8; i++) if (dig_at(v, mode, i) != 0) msd = i;
        return pos > msd;
    endfunction

    function automatic logic [6:0] shown_seg(input logic [31:0] v, input logic [1:0] mode,
                                             input logic blz, input int pos);
        int d = dig_at(v, mode, pos);
        if (is_blanked(v, mode, blz, pos)) return 7'h7F;
        if (mode == 2'd3 && d > 9) return 7'h3F;
        return glyph_tab[d];
    endfunction

    function automatic bit bcd_bad(input logic [31:0] v, input logic [1:0] mode);
        bit bad = 0;
        for (int i = 0; i < 8; i++) if (mode == 2'd3 && dig_at(v, mode, i) > 9) bad = 1;
        return bad;
    endfunction

    // Applies one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        int  n;
        int  pos;
        int  phase;
        bit  pre_ready;
        m_acc = 0;
        if (rst) begin
            m_t = 0; m_pend = 0; m_sv = 0; m_sm = 2'd2; m_sb = 0; m_ready = 0;
            e_an = 8'hFF; e_seg = 7'h7F; e_bcd = 1'b0;
        end else begin
            pre_ready = m_ready;
            m_t++;
            n     = m_t - 1;
            pos   = (n / SLOT) % 8;
            phase = n % SLOT;
            e_seg = shown_seg(m_sv, m_sm, m_sb, pos);
            e_an  = (phase == 0 || is_blanked(m_sv, m_sm, m_sb, pos)) ? 8'hFF : ~(8'(1) << pos);
            e_bcd = bcd_bad(m_sv, m_sm);
            if (in_valid && pre_ready) begin
                m_pend = 1; m_pd = in_data; m_pm = in_mode; m_pb = in_blank_lz;
                m_acc = 1; m_acc_t = m_t;
            end else if (m_t % FRAME == 0 && m_pend) begin
                m_sv = m_pd; m_sm = m_pm; m_sb = m_pb; m_pend = 0;
            end
            m_ready = !m_pend;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("an", an, e_an);
        check_eq("seg", seg, e_seg);
        check_eq("dp", dp, 1);
        check_eq("in_ready", in_ready, m_ready);
        check_eq("bcd_err", bcd_err, e_bcd);
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic b, output int acc_t);
        in_valid = 1'b1; in_data = d; in_mode = m; in_blank_lz = b;
        acc_t = -1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (m_acc) begin
                acc_t = m_acc_t;
                break;
            end
        end
        in_valid = 1'b0; in_data = $urandom; in_mode = 2'($urandom); in_blank_lz = 1'($urandom);
        if (acc_t < 0) check_eq("send_timeout", 0, 1);
    endtask

    // Steps until the given value is on display at mid-slot of digit pos.
    task automatic wait_shown(input logic [31:0] v, input logic [1:0] m, input int pos);
        bit found = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (m_sv == v && m_sm == m && m_t > 0 && (m_t - 1) % FRAME == pos * SLOT + 2) begin
                found = 1;
                break;
            end
        end
        if (!found) check_eq("wait_shown_timeout", 0, 1);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int ta;
        int tb;
        bit found;
        logic [31:0] d;
        logic [1:0]  m;

        // Reset held for three cycles, then ready on the first cycle after release.
        steps(3);
        check_eq("rst_an", an, 8'hFF);
        check_eq("rst_seg", seg, 7'h7F);
        check_eq("rst_ready", in_ready, 0);
        rst = 1'b0;
        step();
        check_eq("ready_after_rst", in_ready, 1);

        // HEX A1 with leading-zero blanking.
        send(32'h000000A1, 2'd2, 1'b1, ta);
        wait_shown(32'h000000A1, 2'd2, 0);
        check_eq("hex_d0_an", an, 8'hFE);
        check_eq("hex_d0_seg", seg, 7'h79);
        steps(SLOT);
        check_eq("hex_d1_an", an, 8'hFD);
        check_eq("hex_d1_seg", seg, 7'h08);
        steps(SLOT);
        check_eq("hex_d2_an", an, 8'hFF);
        check_eq("hex_d2_seg", seg, 7'h7F);
        check_eq("hex_bcd_err", bcd_err, 0);

        // BCD with an invalid nibble, no blanking.
        send(32'h000012F4, 2'd3, 1'b0, ta);
        wait_shown(32'h000012F4, 2'd3, 1);
        check_eq("bcd_d1_seg", seg, 7'h3F);
        check_eq("bcd_d1_an", an, 8'hFD);
        check_eq("bcd_err_set", bcd_err, 1);
        wait_shown(32'h000012F4, 2'd3, 7);
        check_eq("bcd_d7_seg", seg, 7'h40);
        check_eq("bcd_d7_an", an, 8'h7F);

        // OCT 8 = "10" with blanking.
        send(32'd8, 2'd1, 1'b1, ta);
        wait_shown(32'd8, 2'd1, 0);
        check_eq("oct_d0_seg", seg, 7'h40);
        steps(SLOT);
        check_eq("oct_d1_seg", seg, 7'h79);
        steps(SLOT);
        check_eq("oct_d2_an", an, 8'hFF);
        check_eq("oct_d2_seg", seg, 7'h7F);

        // Backpressure: A mid-frame, B stalled until just after the boundary.
        found = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (!m_pend && (m_t - 1) % FRAME == 12) begin
                found = 1;
                break;
            end
        end
        if (!found) check_eq("midframe_timeout", 0, 1);
        send(32'h00000005, 2'd2, 1'b0, ta);
        send(32'h0000000B, 2'd2, 1'b0, tb);
        check_eq("b_accept_phase", 32'(tb % FRAME), 1);
        check_eq("b_stalled", 32'(tb - ta > 2), 1);
        wait_shown(32'h00000005, 2'd2, 0);
        check_eq("a_d0_seg", seg, 7'h12);
        check_eq("a_d0_an", an, 8'hFE);

        // Reset while a value is pending at digit index 5.
        send(32'h00C0FFEE, 2'd2, 1'b0, ta);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (m_pend && (m_t / SLOT) % 8 == 5) begin
                found = 1;
                break;
            end
            step();
        end
        if (!found) check_eq("idx5_timeout", 0, 1);
        rst = 1'b1;
        step();
        check_eq("midrst_an", an, 8'hFF);
        check_eq("midrst_seg", seg, 7'h7F);
        rst = 1'b0;
        step();
        check_eq("midrst_ready", in_ready, 1);
        wait_shown(32'h0, 2'd2, 0);
        check_eq("post_rst_seg", seg, 7'h40);
        check_eq("post_rst_an", an, 8'hFE);
        steps(2 * FRAME);

        // Random traffic in all modes, with leading zeros and mixed BCD validity.
        for (int r = 0; r < 40; r++) begin
            m = 2'($urandom_range(0, 3));
            d = $urandom >> $urandom_range(0, 31);
            if (m == 2'd3 && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) d[4*i +: 4] = 4'(d[4*i +: 4] % 10);
            end
            send(d, m, 1'($urandom_range(0, 1)), ta);
            steps($urandom_range(0, 40));
        end
        steps(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
